write_to_imem: RTL

Loader for the processor's instruction memory. It accepts a byte stream over a valid/ready handshake and packs each group of four bytes into a little-endian 32-bit instruction word. Each word is written into a register-based IMEM at sequential word addresses. The block also provides the combinational word-addressed read port that the fetch stage uses, so one block both fills and serves the IMEM.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_word_assembler.sv | 78 +++++++
 rtl/write_to_imem.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared IMEM definitions: default geometry, loader state encoding and
// byte-lane count. Used by the instruction-memory loader and the fetch stage.
package imem_pkg;

    localparam int IMEM_LEN_DEF   = 32;
    localparam int IMEM_SIZE_DEF  = 10;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_wr_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs an accepted byte stream into little-endian words. Byte k of a word
// lands in bits [8k+7:8k]; word_done strobes combinationally with the byte
// that completes a word, and word_out presents that complete word alongside it.
module imem_word_assembler
    import imem_pkg::*;
#(
    parameter int IMEM_LEN = IMEM_LEN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                byte_accept,
    input  logic [7:0]          byte_in,
    output logic [IMEM_LEN-1:0] word_out,
    output logic                word_done
);

    localparam int LANES = IMEM_LEN / 8;
    localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [IW-1:0] byte_idx_q;
    logic [IW-1:0] byte_idx_d;
    logic [7:0]    lane_q [LANES];
    logic [7:0]    lane_d [LANES];
    logic          last_lane;

    assign last_lane = (byte_idx_q == IW'(LANES - 1));
    assign word_done = byte_accept && last_lane;

    // Byte index: restart on session clear, wrap after the last lane.
    always_comb begin
        byte_idx_d = byte_idx_q;
        if (clear) begin
            byte_idx_d = '0;
        end else if (byte_accept) begin
            byte_idx_d = last_lane ? '0 : byte_idx_q + IW'(1);
        end
    end

    // Byte index register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Capture the incoming byte into the lane currently being filled.
            always_comb begin
                lane_d[gi] = lane_q[gi];
                if (clear) begin
                    lane_d[gi] = '0;
                end else if (byte_accept && (byte_idx_q == IW'(gi))) begin
                    lane_d[gi] = byte_in;
                end
            end

            // Lane storage register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_q[gi] <= '0;
                end else begin
                    lane_q[gi] <= lane_d[gi];
                end
            end

            // The lane being filled this cycle comes straight from the input,
            // so the completed word is available in the same cycle as its
            // last byte.
            assign word_out[8*gi +: 8] = (byte_idx_q == IW'(gi)) ? byte_in : lane_q[gi];
        end
    endgenerate

endmodule

// File: rtl/write_to_imem.sv
// Instruction-memory loader and fetch read port. A load session (start) takes
// bytes over a valid/ready handshake, packs them into words and writes them
// to sequential IMEM addresses until stop or until the memory is full.
// Optional feature macro: IMEM_WRITER_CHECKSUM_EN (running XOR of written
// words on the checksum port; tied to 0 when undefined).
module write_to_imem
    import imem_pkg::*;
#(
    parameter int IMEM_LEN  = IMEM_LEN_DEF,
    parameter int IMEM_SIZE = IMEM_SIZE_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic [7:0]                     byte_in,
    input  logic                           byte_valid,
    output logic                           byte_ready,
    input  logic [31:0]                    rd_addr,
    output logic [IMEM_LEN-1:0]            rd_data,
    output logic                           load_done,
    output logic [$clog2(IMEM_SIZE+1)-1:0] load_count,
    output logic [IMEM_LEN-1:0]            checksum
);

    localparam int CW = $clog2(IMEM_SIZE + 1);
    localparam int AW = (IMEM_SIZE > 1) ? $clog2(IMEM_SIZE) : 1;

    imem_wr_state_t state_q;
    imem_wr_state_t state_d;
    logic           session_start;
    logic           byte_accept;
    logic           word_done;
    logic           last_word;
    logic [IMEM_LEN-1:0] word;

    // The word index doubles as load_count: both clear on session start and
    // step together on every word write.
    logic [CW-1:0] word_idx_q;
    logic [CW-1:0] word_idx_d;

    logic [IMEM_LEN-1:0] mem_q [IMEM_SIZE];
    logic [IMEM_LEN-1:0] mem_d [IMEM_SIZE];

    // Ready and done are pure state decodes so there is no input-to-output path.
    assign byte_ready  = (state_q == LOAD);
    assign load_done   = (state_q == DONE);
    assign byte_accept = byte_valid && byte_ready;
    assign last_word   = (word_idx_q == CW'(IMEM_SIZE - 1));
    assign load_count  = word_idx_q;

    imem_word_assembler #(
        .IMEM_LEN (IMEM_LEN)
    ) u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear       (session_start),
        .byte_accept (byte_accept),
        .byte_in     (byte_in),
        .word_out    (word),
        .word_done   (word_done)
    );

    // Session FSM: filling the last word forces DONE regardless of stop; a
    // byte accepted together with stop is still consumed before leaving LOAD.
    always_comb begin
        state_d       = state_q;
        session_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = LOAD;
                    session_start = 1'b1;
                end
            end
            LOAD: begin
                if (word_done && last_word) begin
                    state_d = DONE;
                end else if (stop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d       = LOAD;
                    session_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word index: restart per session, advance on each completed word.
    always_comb begin
        word_idx_d = word_idx_q;
        if (session_start) begin
            word_idx_d = '0;
        end else if (word_done) begin
            word_idx_d = word_idx_q + CW'(1);
        end
    end

    // Word index register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx_q <= '0;
        end else begin
            word_idx_q <= word_idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < IMEM_SIZE; gi++) begin : g_mem
            // Write the completed word into the slot addressed by word_idx.
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (word_done && (word_idx_q == CW'(gi))) begin
                    mem_d[gi] = word;
                end
            end

            // IMEM word storage; reset zeroes the whole memory.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // Fetch read port: the full 32-bit address is range-checked so aliases
    // above IMEM_SIZE read as zero instead of wrapping.
    always_comb begin
        rd_data = '0;
        if (rd_addr < 32'(IMEM_SIZE)) begin
            rd_data = mem_q[rd_addr[AW-1:0]];
        end
    end

`ifdef IMEM_WRITER_CHECKSUM_EN
    logic [IMEM_LEN-1:0] checksum_q;
    logic [IMEM_LEN-1:0] checksum_d;

    // Running XOR of the words written in the current session.
    always_comb begin
        checksum_d = checksum_q;
        if (session_start) begin
            checksum_d = '0;
        end else if (word_done) begin
            checksum_d = checksum_q ^ word;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule
